// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_pkg
//  Description : Shared types for the memory-access stage: EX/MEM and MEM/WB
//                register layouts, the access FSM encoding, func3 size codes
//                and store-lane / misalignment helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    // func3 access size / signedness codes
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } memstate_t;

    // Memory operation latched from the EX/MEM register while it is in flight
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  func3;
        logic        is_store;
        logic        reg_write;
        logic [4:0]  write_reg;
    } MEM_STATE;

    // MEM/WB register contents
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [4:0]  write_reg;
        logic        reg_write;
    } WB_STATE;

    // Byte enables for an access of size f3 at byte offset lo
    function automatic logic [3:0] lane_be(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_B, F3_BU: return 4'b0001 << lo;
            F3_H, F3_HU: return lo[1] ? 4'b1100 : 4'b0011;
            default:     return 4'b1111;
        endcase
    endfunction

    // Store data replicated across every lane the size could occupy
    function automatic logic [31:0] lane_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            F3_B, F3_BU: return {4{d[7:0]}};
            F3_H, F3_HU: return {2{d[15:0]}};
            default:     return d;
        endcase
    endfunction

    // Halfword not on a 2-byte boundary, or word not on a 4-byte boundary
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: return lo[0];
            F3_W:        return |lo;
            default:     return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
//  Module      : load_align
//  Description : Combinational load-data aligner. Picks the addressed byte or
//                halfword out of the returned word and sign- or zero-extends
//                it according to func3.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_align (
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_addr_lo,
    input  logic [2:0]  i_func3,
    output logic [31:0] o_data
);
    import mem_stage_pkg::*;

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane selection followed by extension
    always_comb begin
        case (i_addr_lo)
            2'd0:    w_byte = i_rdata[7:0];
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        // Halfword position only looks at bit 1; bit 0 is ignored here
        w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        case (i_func3)
            F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_data = {24'd0, w_byte};
            F3_H:    o_data = {{16{w_half[15]}}, w_half};
            F3_HU:   o_data = {16'd0, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : RV32IC memory-access stage. Accepts EX/MEM entries, drives
//                the data-memory req/gnt/rvalid port, aligns load data and
//                emits a one-cycle MEM/WB pulse per entry. Stalls upstream
//                while an access is outstanding; a load whose data never
//                returns completes as a bus error after MAX_WAIT cycles.
//  Options     : MISALIGN_TRAP_EN - misaligned H/W accesses complete
//                immediately with o_misaligned instead of reaching the bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int MAX_WAIT = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_valid,
    input  logic [31:0] i_ALUOutput,
    input  logic [31:0] i_rd2,
    input  logic [2:0]  i_func3,
    input  logic        i_MemRead,
    input  logic        i_MemWrite,
    input  logic        i_RegWrite,
    input  logic        i_MemToReg,
    input  logic [4:0]  i_write_reg,
    output logic        o_stall,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_be,
    input  logic        i_dmem_gnt,
    input  logic        i_dmem_rvalid,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic [31:0] o_wb_data,
    output logic [4:0]  o_wb_write_reg,
    output logic        o_wb_RegWrite,
`ifdef MISALIGN_TRAP_EN
    output logic        o_misaligned,
`endif
    output logic        o_bus_err
);
    import mem_stage_pkg::*;

    localparam int                CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    memstate_t        state_q, state_d;
    MEM_STATE         entry_q, entry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    WB_STATE          wb_q, wb_d;
    logic             bus_err_q, bus_err_d;

    logic             w_mem_op;
    logic             w_mis;
    logic             w_trap;
    logic             w_req;
    logic [31:0]      w_load_data;

    // Write-back source selection is fixed by the load path here
    logic             unused_mem_to_reg;
    assign unused_mem_to_reg = i_MemToReg;

    assign w_mem_op = i_MemRead | i_MemWrite;
`ifdef MISALIGN_TRAP_EN
    assign w_mis = is_misaligned(i_func3, i_ALUOutput[1:0]);
`else
    assign w_mis = 1'b0;
`endif
    assign w_trap = (state_q == ST_IDLE) && i_valid && w_mem_op && w_mis;

    load_align u_load_align (
        .i_rdata   (i_dmem_rdata),
        .i_addr_lo (entry_q.addr[1:0]),
        .i_func3   (entry_q.func3),
        .o_data    (w_load_data)
    );

    // Next-state, entry capture and write-back result
    always_comb begin
        state_d   = state_q;
        entry_d   = entry_q;
        cnt_d     = cnt_q;
        wb_d      = '0;
        bus_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_valid) begin
                    if (!w_mem_op) begin
                        wb_d.valid     = 1'b1;
                        wb_d.data      = i_ALUOutput;
                        wb_d.write_reg = i_write_reg;
                        wb_d.reg_write = i_RegWrite;
                    end else if (w_mis) begin
                        // Trapped access completes at once with no write-back
                        wb_d.valid     = 1'b1;
                        wb_d.write_reg = i_write_reg;
                    end else begin
                        entry_d.addr      = i_ALUOutput;
                        entry_d.wdata     = i_rd2;
                        entry_d.func3     = i_func3;
                        entry_d.is_store  = i_MemWrite;   // read+write counts as store
                        entry_d.reg_write = i_RegWrite;
                        entry_d.write_reg = i_write_reg;
                        state_d           = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (i_dmem_gnt) begin
                    if (entry_q.is_store) begin
                        wb_d.valid     = 1'b1;
                        wb_d.write_reg = entry_q.write_reg;
                        state_d        = ST_IDLE;
                    end else begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (i_dmem_rvalid) begin
                    wb_d.valid     = 1'b1;
                    wb_d.data      = w_load_data;
                    wb_d.write_reg = entry_q.write_reg;
                    wb_d.reg_write = entry_q.reg_write;
                    state_d        = ST_IDLE;
                end else if (cnt_q == WAIT_LAST) begin
                    wb_d.valid     = 1'b1;
                    wb_d.write_reg = entry_q.write_reg;
                    bus_err_d      = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and pipeline registers
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= ST_IDLE;
            entry_q   <= '0;
            cnt_q     <= '0;
            wb_q      <= '0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            entry_q   <= entry_d;
            cnt_q     <= cnt_d;
            wb_q      <= wb_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misaligned_q, misaligned_d;

    // Misalignment flag accompanies the trapped write-back pulse
    always_comb begin
        misaligned_d = w_trap;
    end

    // Misalignment flag register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            misaligned_q <= 1'b0;
        end else begin
            misaligned_q <= misaligned_d;
        end
    end

    assign o_misaligned = misaligned_q;
`else
    logic unused_trap;
    assign unused_trap = w_trap;
`endif

    // Bus request is driven from the latched entry so it stays stable until grant
    assign w_req        = (state_q == ST_REQ);
    assign o_dmem_req   = w_req;
    assign o_dmem_we    = w_req && entry_q.is_store;
    assign o_dmem_addr  = w_req ? {entry_q.addr[31:2], 2'b00} : 32'd0;
    assign o_dmem_be    = w_req ? lane_be(entry_q.func3, entry_q.addr[1:0]) : 4'd0;
    assign o_dmem_wdata = (w_req && entry_q.is_store) ? lane_wdata(entry_q.func3, entry_q.wdata) : 32'd0;

    assign o_stall = (state_q != ST_IDLE) || (i_valid && w_mem_op && !w_mis);

    assign o_wb_valid     = wb_q.valid;
    assign o_wb_data      = wb_q.data;
    assign o_wb_write_reg = wb_q.write_reg;
    assign o_wb_RegWrite  = wb_q.reg_write;
    assign o_bus_err      = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Scoreboard bench for mem_stage. A driver issues entries and
//                plays the memory side; expected write-back results from a
//                behavioural model are queued and a negedge monitor checks them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;
    localparam int MAX_WAIT = 255;

    logic        clk = 1'b0;
    logic        i_reset, i_valid, i_MemRead, i_MemWrite, i_RegWrite, i_MemToReg;
    logic [31:0] i_ALUOutput, i_rd2, i_dmem_rdata;
    logic [2:0]  i_func3;
    logic [4:0]  i_write_reg;
    logic        i_dmem_gnt, i_dmem_rvalid;
    logic        o_stall, o_dmem_req, o_dmem_we, o_wb_valid, o_wb_RegWrite, o_bus_err;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;
    logic [3:0]  o_dmem_be;
    logic [4:0]  o_wb_write_reg;
`ifdef MISALIGN_TRAP_EN
    logic        o_misaligned;
`endif

    mem_stage #(.MAX_WAIT(MAX_WAIT)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_valid(i_valid),
        .i_ALUOutput(i_ALUOutput), .i_rd2(i_rd2), .i_func3(i_func3),
        .i_MemRead(i_MemRead), .i_MemWrite(i_MemWrite), .i_RegWrite(i_RegWrite),
        .i_MemToReg(i_MemToReg), .i_write_reg(i_write_reg),
        .o_stall(o_stall), .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we),
        .o_dmem_addr(o_dmem_addr), .o_dmem_wdata(o_dmem_wdata), .o_dmem_be(o_dmem_be),
        .i_dmem_gnt(i_dmem_gnt), .i_dmem_rvalid(i_dmem_rvalid), .i_dmem_rdata(i_dmem_rdata),
        .o_wb_valid(o_wb_valid), .o_wb_data(o_wb_data), .o_wb_write_reg(o_wb_write_reg),
        .o_wb_RegWrite(o_wb_RegWrite),
`ifdef MISALIGN_TRAP_EN
        .o_misaligned(o_misaligned),
`endif
        .o_bus_err(o_bus_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] data;
        logic        chk_data;
        logic [4:0]  wreg;
        logic        regw;
        logic        berr;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   mon_en   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model (plain arithmetic) ----------------
    function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [31:0] a, input logic [2:0] f3);
        logic [31:0] v;
        int unsigned boff;
        boff = a % 4;
        case (f3)
            3'd0, 3'd4: begin
                v = (rd >> (8 * boff)) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
            end
            3'd1, 3'd5: begin
                v = (rd >> (16 * (boff / 2))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'd32768) v = v - 32'd65536;
            end
            default: v = rd;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned boff;
        boff = a % 4;
        if (f3 == 3'd0 || f3 == 3'd4) return 4'(1 << boff);
        if (f3 == 3'd1 || f3 == 3'd5) return 4'(3 << (2 * (boff / 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
        if (f3 == 3'd0 || f3 == 3'd4) return (d & 32'hFF) * 32'h01010101;
        if (f3 == 3'd1 || f3 == 3'd5) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction

    function automatic bit model_trap(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        if ((f3 == 3'd1 || f3 == 3'd5) && (a % 2 != 0)) return 1'b1;
        if (f3 == 3'd2 && (a % 4 != 0)) return 1'b1;
`endif
        return 1'b0;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (mon_en) begin
            if (o_bus_err && !o_wb_valid) check("bus_err_without_wb", {31'd0, o_bus_err}, 32'd0);
            if (o_wb_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_wb_valid", {31'd0, o_wb_valid}, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("wb_cycle", cyc, e.cyc);
                    check("wb_write_reg", {27'd0, o_wb_write_reg}, {27'd0, e.wreg});
                    check("wb_RegWrite", {31'd0, o_wb_RegWrite}, {31'd0, e.regw});
                    check("wb_bus_err", {31'd0, o_bus_err}, {31'd0, e.berr});
                    if (e.chk_data) check("wb_data", o_wb_data, e.data);
`ifdef MISALIGN_TRAP_EN
                    check("wb_misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
`endif
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Called at posedge+1; returns at posedge+1.
    task automatic do_txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] rd2, input logic [4:0] wreg, input bit regw,
                          input int gdly, input int rdly, input logic [31:0] rdata);
        exp_t e;
        bit   mem, trap;
        int   acc, g;
        mem  = rd | wr;
        trap = mem && model_trap(f3, addr);
        i_valid = 1'b1; i_ALUOutput = addr; i_rd2 = rd2; i_func3 = f3;
        i_MemRead = rd; i_MemWrite = wr; i_RegWrite = regw; i_MemToReg = rd; i_write_reg = wreg;
        #1;
        check("stall_on_accept", {31'd0, o_stall}, {31'd0, mem && !trap});
        @(posedge clk); #1;
        acc = cyc;
        e = '{data: 32'd0, chk_data: 1'b1, wreg: wreg, regw: 1'b0, berr: 1'b0, mis: 1'b0, cyc: acc};
        if (!mem) begin
            e.data = addr; e.regw = regw;
            sb.push_back(e);
            return;
        end
        i_valid = 1'b0;
        if (trap) begin
            e.mis = 1'b1;
            sb.push_back(e);
            check("trap_no_req", {31'd0, o_dmem_req}, 32'd0);
            return;
        end
        check("req", {31'd0, o_dmem_req}, 32'd1);
        check("dmem_addr", o_dmem_addr, addr & 32'hFFFF_FFFC);
        check("dmem_we", {31'd0, o_dmem_we}, {31'd0, wr});
        if (wr) begin
            check("dmem_be", {28'd0, o_dmem_be}, {28'd0, model_be(f3, addr)});
            check("dmem_wdata", o_dmem_wdata, model_wdata(f3, rd2));
        end
        // REQ phase with stray rvalid noise that must be ignored
        repeat (gdly) begin
            i_dmem_rvalid = 1'($urandom % 2); i_dmem_rdata = $urandom;
            @(posedge clk); #1;
            check("req_held", {o_dmem_req, o_dmem_addr[31:1]}, {1'b1, addr[31:2], 1'b0});
        end
        i_dmem_rvalid = 1'b0; i_dmem_gnt = 1'b1;
        @(posedge clk); #1;
        g = cyc; i_dmem_gnt = 1'b0;
        if (wr) begin
            e.chk_data = 1'b0; e.cyc = g;
            sb.push_back(e);
            return;
        end
        check("stall_in_wait", {31'd0, o_stall}, 32'd1);
        if (rdly >= MAX_WAIT) begin
            e.berr = 1'b1; e.cyc = g + MAX_WAIT;
            sb.push_back(e);
            repeat (MAX_WAIT + 1) @(posedge clk);
            #1;
            check("stall_after_timeout", {31'd0, o_stall}, 32'd0);
            return;
        end
        repeat (rdly) begin
            i_dmem_gnt = 1'($urandom % 2);
            @(posedge clk); #1;
        end
        i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
        e.data = model_load(rdata, addr, f3); e.regw = regw; e.cyc = g + rdly + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        i_dmem_rvalid = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        i_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        logic [2:0] f3s [5];
        f3s = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        i_reset = 1'b1; i_valid = 1'b0; i_ALUOutput = '0; i_rd2 = '0; i_func3 = '0;
        i_MemRead = 1'b0; i_MemWrite = 1'b0; i_RegWrite = 1'b0; i_MemToReg = 1'b0;
        i_write_reg = '0; i_dmem_gnt = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_wb_valid", {31'd0, o_wb_valid}, 32'd0);
        check("rst_req", {31'd0, o_dmem_req}, 32'd0);
        check("rst_stall", {31'd0, o_stall}, 32'd0);
        check("rst_bus_err", {31'd0, o_bus_err}, 32'd0);
        check("rst_outputs", o_wb_data | o_dmem_addr | o_dmem_wdata | {27'd0, o_wb_write_reg}, 32'd0);
        i_reset = 1'b0; mon_en = 1'b1;
        idle_cycles(1);

        // Directed cases
        do_txn(0, 0, 3'd0, 32'h1234, 32'd0, 5'd5, 1, 0, 0, 0);
        do_txn(0, 1, 3'd0, 32'h103, 32'hAB, 5'd7, 0, 0, 0, 0);
        do_txn(1, 0, 3'd0, 32'h102, 32'd0, 5'd9, 1, 2, 2, 32'h0080_0000);
        do_txn(1, 0, 3'd4, 32'h102, 32'd0, 5'd9, 1, 2, 2, 32'h0080_0000);
        do_txn(1, 0, 3'd2, 32'h102, 32'd0, 5'd3, 1, 0, 0, 32'hDEAD_BEEF);
        do_txn(1, 0, 3'd1, 32'h202, 32'd0, 5'd4, 1, 0, 0, 32'h8001_7FFF);
        do_txn(1, 1, 3'd1, 32'h302, 32'h1234_CAFE, 5'd6, 1, 1, 0, 0);
        do_txn(1, 0, 3'd2, 32'h400, 32'd0, 5'd8, 1, 0, MAX_WAIT, 0);
        idle_cycles(2);

        // Reset while waiting for read data: the late rvalid must be dropped
        i_valid = 1'b1; i_ALUOutput = 32'h500; i_func3 = 3'd2; i_MemRead = 1'b1;
        i_MemWrite = 1'b0; i_RegWrite = 1'b1; i_write_reg = 5'd10;
        @(posedge clk); #1;
        i_valid = 1'b0; i_dmem_gnt = 1'b1;
        @(posedge clk); #1;
        i_dmem_gnt = 1'b0;
        @(posedge clk); #1;
        i_reset = 1'b1;
        @(posedge clk); #1;
        i_reset = 1'b0;
        check("reset_req", {31'd0, o_dmem_req}, 32'd0);
        check("reset_stall", {31'd0, o_stall}, 32'd0);
        i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1111_2222;
        @(posedge clk); #1;
        i_dmem_rvalid = 1'b0;
        check("reset_no_wb", {31'd0, o_wb_valid}, 32'd0);
        idle_cycles(2);

        // Randomised traffic, including back-to-back non-memory ops
        for (int n = 0; n < 200; n++) begin
            int kind;
            bit rdb, wrb;
            kind = $urandom_range(0, 2);
            rdb = (kind == 1) || (kind == 2 && $urandom_range(0, 3) == 0);
            wrb = (kind == 2);
            do_txn(rdb, wrb, f3s[$urandom_range(0, 4)], $urandom, $urandom,
                   5'($urandom), 1'($urandom % 2), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom);
            if ($urandom_range(0, 4) == 0) idle_cycles($urandom_range(1, 2));
        end
        idle_cycles(4);
        check("scoreboard_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the RV32IC pipeline and the consumer of the execute-stage outputs. Takes the EX/MEM pipeline register contents (ALU result, store data, func3, control bits), performs loads/stores on the data-memory port with a req/gnt/rvalid handshake, aligns and sign-extends load data, and presents the MEM/WB result to write-back. Stalls the pipeline while an access is outstanding.

## Interface
- MAX_WAIT, 255: cycles allowed between grant and rvalid before bus-error completion
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-high reset
- i_valid  in  1  EX/MEM entry valid
- i_ALUOutput  in  32  address (mem op) or result (non-mem op)
- i_rd2  in  32  store data
- i_func3  in  3  access size/sign (0 B, 1 H, 2 W, 4 BU, 5 HU)
- i_MemRead, i_MemWrite, i_RegWrite, i_MemToReg  in  1 each  control bits
- i_write_reg  in  5  destination register
- o_stall  out  1  hold EX and earlier stages
- o_dmem_req  out  1  request
- o_dmem_we  out  1  write enable
- o_dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- o_dmem_wdata  out  32  lane-replicated store data
- o_dmem_be  out  4  byte enables
- i_dmem_gnt  in  1  request accepted
- i_dmem_rvalid  in  1  read data valid
- i_dmem_rdata  in  32  read data
- o_wb_valid  out  1  one-cycle pulse, MEM/WB entry valid
- o_wb_data  out  32  result to write back
- o_wb_write_reg  out  5  destination register
- o_wb_RegWrite  out  1  write-back enable
- o_bus_err  out  1  one-cycle pulse on MAX_WAIT expiry
- o_misaligned  out  1  only with MISALIGN_TRAP_EN

## Operation
- FSM states IDLE, REQ, WAIT. Reset: IDLE; all outputs 0.
- IDLE, i_valid, neither MemRead nor MemWrite: next cycle o_wb_valid=1, o_wb_data=i_ALUOutput, RegWrite/write_reg passed through; stay IDLE.
- IDLE, i_valid with MemRead or MemWrite: latch entry, go REQ. MemRead and MemWrite both set: treated as store.
- REQ: o_dmem_req=1, address/be/wdata/we held stable until i_dmem_gnt. On gnt: store -> WB pulse next cycle (o_wb_RegWrite=0), IDLE; load -> WAIT, clear wait counter.
- WAIT: on i_dmem_rvalid, o_wb_data = aligned rdata, WB pulse next cycle, IDLE. Counter reaching MAX_WAIT: o_bus_err and WB pulse with o_wb_data=0, o_wb_RegWrite=0, IDLE.
- Store lanes: SB be=1<<addr[1:0], wdata={4{rd2[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{rd2[15:0]}}; SW be=1111.
- Load align: select byte by addr[1:0], half by addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
- o_stall = (state != IDLE) || (IDLE && i_valid && mem op).
- i_dmem_rvalid/gnt outside the state expecting them: ignored.
- Reset mid-access: IDLE next edge, req drops, pending rvalid discarded, no WB pulse.

## Timing
- Non-mem op: 1 cycle i_valid -> o_wb_valid.
- Store, gnt in first REQ cycle: o_wb_valid 2 cycles after acceptance.
- Load, gnt and rvalid each in first possible cycle: o_wb_valid 3 cycles after acceptance.
- New entry accepted only in IDLE; back-to-back non-mem ops one per cycle.

## Configuration
- MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1, LW/SW with addr[1:0]!=0 issue no request; o_misaligned and o_wb_valid pulse 1 cycle after acceptance, o_wb_RegWrite=0, stay IDLE.
- Undefined: no o_misaligned port; offending low address bits ignored (H uses addr[1], W ignores addr[1:0]).

## Structure
- PipelineReg package: MEM_STATE (existing) and new WB_STATE struct, memstate_t FSM enum, func3 size constants.
- Sub-module load_align: combinational rdata/addr[1:0]/func3 -> 32-bit extended result.

## Test plan
- Non-mem: i_ALUOutput=0x1234, write_reg=5, RegWrite=1 -> next cycle o_wb_data=0x1234, o_wb_write_reg=5.
- SB addr=0x103, rd2=0xAB, gnt immediate -> o_dmem_addr=0x100, be=1000, wdata=0xABABABAB, WB pulse 2 cycles later, RegWrite=0.
- LB addr=0x102, rdata=0x00800000, gnt after 2 cycles, rvalid after 3 -> o_wb_data=0xFFFFFF80; LBU same -> 0x00000080; o_stall high throughout.
- Load, rvalid never asserted -> o_bus_err after MAX_WAIT=255 cycles in WAIT, o_wb_RegWrite=0, IDLE.
- i_reset during WAIT, then rvalid -> no WB pulse, o_dmem_req=0, o_stall=0.
- MISALIGN_TRAP_EN, LW addr=0x102 -> no o_dmem_req, o_misaligned pulse 1 cycle later; without macro -> o_dmem_addr=0x100, full word returned.
